// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types and constants for the DVP test-pattern source.
//   dvp_state_t : frame FSM states
//   PAT_*       : pattern_sel encodings
//   BAR_STEP    : level drop between adjacent colour bars (10-bit scale)
//   max_int     : helper for sizing counters from line-count parameters
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } dvp_state_t;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_HRAMP = 2'd1;
    localparam logic [1:0] PAT_VRAMP = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    localparam int BAR_STEP = 128;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// dvp_timing_gen: frame FSM plus horizontal (x) and line-in-state (y) counters.
//   clk, reset_n : clock, asynchronous active-low reset
//   pix_ce       : advance enable; all state holds while low
//   enable       : run request, sampled in IDLE and at the end of VFRONT
//   state, x, y  : position the output registers load on the next enabled edge
//                  (i.e. the upcoming state/x/y, not the current registered one)
//   href_next    : HREF value for that upcoming position
//   vsync_next   : VSYNC value for that upcoming position
//   frame_end    : high on the cycle that leaves VFRONT
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE     = 1920,
    parameter int H_BLANK      = 280,
    parameter int V_ACTIVE     = 1080,
    parameter int VSYNC_LINES  = 4,
    parameter int VBACK_LINES  = 16,
    parameter int VFRONT_LINES = 4,
    parameter int XW           = 12,
    parameter int YW           = 11
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pix_ce,
    input  logic            enable,
    output dvp_state_t      state,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic            href_next,
    output logic            vsync_next,
    output logic            frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;

    dvp_state_t      state_reg, state_next;
    logic [XW-1:0]   x_reg, x_next;
    logic [YW-1:0]   y_reg, y_next;
    int              state_lines;
    logic            line_end;
    logic            state_end;

    always_comb begin
        state_lines = 1;
        case (state_reg)
            VSYNC:   state_lines = VSYNC_LINES;
            VBACK:   state_lines = VBACK_LINES;
            ACTIVE:  state_lines = V_ACTIVE;
            VFRONT:  state_lines = VFRONT_LINES;
            default: state_lines = 1;
        endcase

        line_end   = (x_reg == XW'(H_TOTAL - 1));
        state_end  = line_end && (int'(y_reg) == state_lines - 1);

        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        frame_end  = 1'b0;

        // x and y stay at zero in IDLE, so a new frame always starts at the
        // top-left of VSYNC.
        if (state_reg == IDLE) begin
            if (enable) begin
                state_next = VSYNC;
            end
        end else begin
            if (line_end) begin
                x_next = '0;
                y_next = y_reg + YW'(1);
            end else begin
                x_next = x_reg + XW'(1);
            end

            if (state_end) begin
                y_next = '0;
                case (state_reg)
                    VSYNC:  state_next = VBACK;
                    VBACK:  state_next = ACTIVE;
                    ACTIVE: state_next = VFRONT;
                    VFRONT: begin
                        // A frame is only started or stopped at its boundary.
                        frame_end  = 1'b1;
                        state_next = enable ? VSYNC : IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        href_next  = (state_next == ACTIVE) && (int'(x_next) < H_ACTIVE);
        vsync_next = (state_next == VSYNC);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
        end else if (pix_ce) begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    assign state = state_next;
    assign x     = x_next;
    assign y     = y_next;

endmodule

// File: rtl/dvp_pattern_source.sv
// dvp_pattern_source: OV5642-style DVP transmitter producing VSYNC/HREF/DATA
// frames with a selectable test pattern.
//   clk, reset_n  : pixel-rate clock, asynchronous active-low reset
//   pix_ce        : pixel enable; everything holds while low
//   enable        : run request (frames are never truncated)
//   pattern_sel   : 0 bars, 1 horizontal ramp, 2 vertical ramp, 3 flat
//   flat_value    : level for the flat pattern
//   dvp_vsync     : frame sync, active high
//   dvp_href      : line valid
//   dvp_data      : pixel, 0 while HREF is low
//   frame_count   : completed frames, wraps
//   busy          : high whenever the FSM is not in IDLE
module dvp_pattern_source
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE     = 1920,
    parameter int H_BLANK      = 280,
    parameter int V_ACTIVE     = 1080,
    parameter int VSYNC_LINES  = 4,
    parameter int VBACK_LINES  = 16,
    parameter int VFRONT_LINES = 4,
    parameter int DATA_W       = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_ce,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] flat_value,
    output logic              dvp_vsync,
    output logic              dvp_href,
    output logic [DATA_W-1:0] dvp_data,
    output logic [15:0]       frame_count,
    output logic              busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int Y_MAX   = max_int(max_int(V_ACTIVE, VSYNC_LINES),
                                     max_int(VBACK_LINES, VFRONT_LINES));
    localparam int YW      = (Y_MAX > 1) ? $clog2(Y_MAX) : 1;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    dvp_state_t        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              href_next;
    logic              vsync_next;
    logic              frame_end;

    logic [1:0]        pat_reg;
    logic [DATA_W-1:0] flat_reg;
    logic [2:0]        bar_reg, bar_next;
    logic [BW-1:0]     bar_cnt_reg, bar_cnt_next;
    logic [9:0]        bar_lvl10;
    logic [DATA_W-1:0] bar_lvl;
    logic [DATA_W-1:0] data_next;

    dvp_timing_gen #(
        .H_ACTIVE     (H_ACTIVE),
        .H_BLANK      (H_BLANK),
        .V_ACTIVE     (V_ACTIVE),
        .VSYNC_LINES  (VSYNC_LINES),
        .VBACK_LINES  (VBACK_LINES),
        .VFRONT_LINES (VFRONT_LINES),
        .XW           (XW),
        .YW           (YW)
    ) u_timing (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_ce     (pix_ce),
        .enable     (enable),
        .state      (state),
        .x          (x),
        .y          (y),
        .href_next  (href_next),
        .vsync_next (vsync_next),
        .frame_end  (frame_end)
    );

    // Bar index tracked by a width counter instead of dividing x. The bar
    // saturates at 7 so any pixels past 8*BAR_W stay in the last bar.
    always_comb begin
        bar_next     = bar_reg;
        bar_cnt_next = bar_cnt_reg;
        if (x == '0) begin
            bar_next     = 3'd0;
            bar_cnt_next = '0;
        end else if (bar_cnt_reg == BW'(BAR_W - 1)) begin
            bar_cnt_next = '0;
            if (bar_reg != 3'd7) begin
                bar_next = bar_reg + 3'd1;
            end
        end else begin
            bar_cnt_next = bar_cnt_reg + BW'(1);
        end
    end

    assign bar_lvl10 = 10'(1023 - BAR_STEP * int'(bar_next));

    if (DATA_W >= 10) begin : g_lvl_up
        assign bar_lvl = DATA_W'(bar_lvl10) << (DATA_W - 10);
    end else begin : g_lvl_down
        assign bar_lvl = DATA_W'(bar_lvl10 >> (10 - DATA_W));
    end

    always_comb begin
        data_next = '0;
        if (href_next) begin
            case (pat_reg)
                PAT_BARS:  data_next = bar_lvl;
                PAT_HRAMP: data_next = DATA_W'(x);
                PAT_VRAMP: data_next = DATA_W'(y);
                default:   data_next = flat_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= '0;
            frame_count <= '0;
            busy        <= 1'b0;
            pat_reg     <= PAT_BARS;
            flat_reg    <= '0;
            bar_reg     <= '0;
            bar_cnt_reg <= '0;
        end else if (pix_ce) begin
            dvp_vsync   <= vsync_next;
            dvp_href    <= href_next;
            dvp_data    <= data_next;
            busy        <= (state != IDLE);
            bar_reg     <= bar_next;
            bar_cnt_reg <= bar_cnt_next;
            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
            end
            // Rising edge of VSYNC marks frame entry: capture the pattern
            // settings here so they are frozen for the whole frame.
            if (vsync_next && !dvp_vsync) begin
                pat_reg  <= pattern_sel;
                flat_reg <= flat_value;
            end
        end
    end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Testbench for dvp_pattern_source with a small 140-cycle frame.
// The reference model tracks only "running" and the cycle position inside
// the frame; every output is derived from that position arithmetically.
module tb_dvp_pattern_source;

    localparam int H_ACTIVE = 16;
    localparam int H_BLANK  = 4;
    localparam int V_ACTIVE = 4;
    localparam int VS_L     = 1;
    localparam int VB_L     = 1;
    localparam int VF_L     = 1;
    localparam int DATA_W   = 10;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int FRAME    = H_TOTAL * (VS_L + VB_L + V_ACTIVE + VF_L);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pix_ce = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        pattern_sel = 2'd0;
    logic [DATA_W-1:0] flat_value = '0;
    logic              dvp_vsync;
    logic              dvp_href;
    logic [DATA_W-1:0] dvp_data;
    logic [15:0]       frame_count;
    logic              busy;

    dvp_pattern_source #(
        .H_ACTIVE     (H_ACTIVE),
        .H_BLANK      (H_BLANK),
        .V_ACTIVE     (V_ACTIVE),
        .VSYNC_LINES  (VS_L),
        .VBACK_LINES  (VB_L),
        .VFRONT_LINES (VF_L),
        .DATA_W       (DATA_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .flat_value  (flat_value),
        .dvp_vsync   (dvp_vsync),
        .dvp_href    (dvp_href),
        .dvp_data    (dvp_data),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_frames = 0;
    int m_pat = 0;
    int m_flat = 0;
    bit check_en = 1'b0;
    int href_ce_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs implied by a frame position.
    function automatic void exp_at(input bit run, input int pos, input int pat, input int flat,
                                   output bit vs, output bit hr, output int data);
        int line, col, bar;
        line = pos / H_TOTAL;
        col  = pos % H_TOTAL;
        vs   = run && (line < VS_L);
        hr   = run && (line >= VS_L + VB_L) && (line < VS_L + VB_L + V_ACTIVE) && (col < H_ACTIVE);
        data = 0;
        if (hr) begin
            case (pat)
                0: begin
                    bar  = col / (H_ACTIVE / 8);
                    if (bar > 7) bar = 7;
                    data = 1023 - 128 * bar;
                end
                1: data = col % (1 << DATA_W);
                2: data = (line - VS_L - VB_L) % (1 << DATA_W);
                default: data = flat;
            endcase
        end
    endfunction

    task automatic model_step();
        if (!reset_n || !pix_ce) return;
        if (!m_run) begin
            if (enable) begin
                m_run = 1'b1; m_pos = 0; m_pat = pattern_sel; m_flat = flat_value;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_frames++;
                m_pos = 0;
                if (enable) begin
                    m_pat = pattern_sel; m_flat = flat_value;
                end else begin
                    m_run = 1'b0;
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // return at the following negedge.
    task automatic tick(input bit ce, input bit en);
        pix_ce = ce;
        enable = en;
        if (ce && dvp_href) href_ce_cnt++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin : compare_proc
        bit vs, hr;
        int d;
        if (check_en) begin
            exp_at(m_run, m_pos, m_pat, m_flat, vs, hr, d);
            check("vsync", int'(dvp_vsync), int'(vs));
            check("href", int'(dvp_href), int'(hr));
            check("data", int'(dvp_data), d);
            check("frame_count", int'(frame_count), m_frames % 65536);
            check("busy", int'(busy), int'(m_run));
        end
    end

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
    endtask

    initial begin : watchdog
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    initial begin : stim
        int fb;
        int guard;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("rst_vsync", int'(dvp_vsync), 0);
        check("rst_href", int'(dvp_href), 0);
        check("rst_data", int'(dvp_data), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        tick(1, 0);
        tick(1, 0);
        check("idle_busy", int'(busy), 0);

        // Frame 1: colour bars; sel changed mid-frame must not take effect.
        pattern_sel = 2'd0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1, 1);
            case (i)
                0:   check("lit_vsync_rise", int'(dvp_vsync), 1);
                19:  check("lit_vsync_last", int'(dvp_vsync), 1);
                20:  check("lit_vsync_fall", int'(dvp_vsync), 0);
                39:  check("lit_href_pre", int'(dvp_href), 0);
                40:  check("lit_bar0", int'(dvp_data), 1023);
                42:  check("lit_bar1", int'(dvp_data), 895);
                55:  check("lit_bar7", int'(dvp_data), 127);
                56:  check("lit_blank_data", int'(dvp_data), 0);
                100: pattern_sel = 2'd1;
                102: check("lit_latch_bars", int'(dvp_data), 895);
                default: ;
            endcase
        end
        tick(1, 1);
        check("lit_frame_count1", int'(frame_count), 1);

        // Frame 2: horizontal ramp.
        for (int i = 1; i < FRAME; i++) begin
            tick(1, 1);
            case (i)
                45: check("lit_hramp5", int'(dvp_data), 5);
                60: begin pattern_sel = 2'd2; flat_value = 10'h3FF; end
                65: check("lit_latch_hramp", int'(dvp_data), 5);
                default: ;
            endcase
        end
        tick(1, 1);

        // Frame 3: vertical ramp.
        for (int i = 1; i < FRAME; i++) begin
            tick(1, 1);
            case (i)
                60:  check("lit_vramp1", int'(dvp_data), 1);
                100: check("lit_vramp3", int'(dvp_data), 3);
                110: begin pattern_sel = 2'd3; flat_value = 10'h2AA; end
                default: ;
            endcase
        end
        tick(1, 1);

        // Frame 4: flat 0x2AA; a later flat_value change waits for next frame.
        for (int i = 1; i < FRAME; i++) begin
            tick(1, 1);
            if (i == 30) flat_value = 10'h155;
            if (i == 50) check("lit_flat", int'(dvp_data), 10'h2AA);
        end
        tick(1, 1);

        // Frame 5: 5-cycle pix_ce stall mid-line.
        href_ce_cnt = 0;
        for (int i = 1; i < FRAME; i++) begin
            tick(1, 1);
            if (i == 45) begin
                for (int k = 0; k < 5; k++) begin
                    tick(0, 1);
                    check("stall_href", int'(dvp_href), 1);
                    check("stall_data", int'(dvp_data), 10'h155);
                end
            end
        end
        tick(1, 1);
        check("stall_href_count", href_ce_cnt, 4 * H_ACTIVE);

        // Randomised running: random stalls and mid-frame setting changes.
        repeat (6 * FRAME) begin
            if ($urandom_range(0, 19) == 0) begin
                pattern_sel = 2'($urandom_range(0, 3));
                flat_value  = 10'($urandom);
            end
            tick($urandom_range(0, 7) != 0, 1);
        end

        // Align to a frame boundary, then drop enable at position 50.
        guard = 0;
        while (!(m_run && m_pos == 0) && guard < 4 * FRAME) begin
            tick($urandom_range(0, 3) != 0, 1);
            guard++;
        end
        check("align_timeout", int'(guard < 4 * FRAME), 1);
        fb = m_frames;
        for (int i = 1; i < 50; i++) tick(1, 1);
        repeat (250) begin
            if ($urandom_range(0, 9) == 0) pattern_sel = 2'($urandom_range(0, 3));
            tick($urandom_range(0, 5) != 0, 0);
        end
        check("stop_busy", int'(busy), 0);
        check("stop_vsync", int'(dvp_vsync), 0);
        check("stop_frame_count", int'(frame_count), (fb + 1) % 65536);

        // Asynchronous reset mid-frame at cycle 70.
        pattern_sel = 2'd1;
        for (int i = 0; i < 70; i++) tick(1, 1);
        #2;
        reset_n = 1'b0;
        m_run = 1'b0; m_pos = 0; m_frames = 0;
        #1;
        check("arst_vsync", int'(dvp_vsync), 0);
        check("arst_href", int'(dvp_href), 0);
        check("arst_data", int'(dvp_data), 0);
        check("arst_frame_count", int'(frame_count), 0);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        repeat (3) tick(1, 1);
        reset_n = 1'b1;
        repeat (3) tick(1, 0);
        check("post_rst_idle", int'(busy), 0);
        tick(1, 1);
        check("post_rst_vsync", int'(dvp_vsync), 1);
        for (int i = 0; i < FRAME; i++) tick(1, 0);
        check("post_rst_frame_count", int'(frame_count), 1);
        check("post_rst_busy", int'(busy), 0);

        check_en = 1'b0;
        summary();
        $finish;
    end

endmodule
